// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// The index-validity check is shared so storage and scoreboard agree on which registers exist.
package reg_file_pkg;

  localparam int DEF_WIDTH    = 64;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_ZERO_REG = 31;

  // True when idx names a real, writable register (in range and not the hardwired zero).
  function automatic logic idx_valid(input logic [31:0] idx,
                                     input int unsigned depth,
                                     input int unsigned zero_reg);
    return (idx < depth) && (idx != zero_reg);
  endfunction

endpackage

// File: rtl/register_file_scoreboard.sv
// Busy scoreboard: one bit per register, set by reserve, cleared by write,
// with a registered population count kept in step with the bits.
module register_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reserve_address,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   busy_count
);

  logic             wr_ok;
  logic             rsv_ok;
  logic [DEPTH-1:0] busy_next;
  logic [ADDR_W:0]  count_next;

  assign wr_ok  = write   && idx_valid(32'(address), DEPTH, ZERO_REG);
  assign rsv_ok = reserve && idx_valid(32'(reserve_address), DEPTH, ZERO_REG);

  // Set dominates clear: a fresh reservation outlives the retiring result.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
    logic set_hit;
    logic clr_hit;
    assign set_hit       = rsv_ok && (reserve_address == ADDR_W'(gi));
    assign clr_hit       = wr_ok  && (address == ADDR_W'(gi));
    assign busy_next[gi] = set_hit || (busy[gi] && !clr_hit);
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + (ADDR_W+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

endmodule

// File: rtl/register_file_scoreboarded.sv
// DEPTH x WIDTH register file: two combinational read ports, one write port,
// optional write-to-read bypass, hardwired zero register and a busy scoreboard.
module register_file_scoreboarded
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] select_a,
  input  logic [ADDR_W-1:0] select_b,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reserve_address,
  output logic [ADDR_W:0]   busy_count
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  busy_vec;
  logic              wr_en;
  logic              rsv_en;
  logic [ADDR_W-1:0] sel     [2];
  logic [WIDTH-1:0]  rd_data [2];
  logic              rd_busy [2];

  assign wr_en  = write   && idx_valid(32'(address), DEPTH, ZERO_REG);
  assign rsv_en = reserve && idx_valid(32'(reserve_address), DEPTH, ZERO_REG);

  // Storage is reset asynchronously, so it lives in flops rather than block RAM.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        mem[gi] <= '0;
      end else if (wr_en && (address == ADDR_W'(gi))) begin
        mem[gi] <= data_in;
      end
    end
  end

  register_file_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock           (clock),
    .reset           (reset),
    .write           (write),
    .address         (address),
    .reserve         (reserve),
    .reserve_address (reserve_address),
    .busy            (busy_vec),
    .busy_count      (busy_count)
  );

  assign sel[0] = select_a;
  assign sel[1] = select_b;

  // Reads are forced to zero while reset is held so a bypassed write cannot leak out.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    always_comb begin
      rd_data[gi] = '0;
      rd_busy[gi] = 1'b0;
      if (reset && idx_valid(32'(sel[gi]), DEPTH, ZERO_REG)) begin
        if ((BYPASS != 0) && wr_en && (address == sel[gi])) begin
          rd_data[gi] = data_in;
          rd_busy[gi] = rsv_en && (reserve_address == sel[gi]);
        end else begin
          rd_data[gi] = mem[sel[gi]];
          rd_busy[gi] = busy_vec[sel[gi]];
        end
      end
    end
  end

  assign out_a  = rd_data[0];
  assign out_b  = rd_data[1];
  assign busy_a = rd_busy[0];
  assign busy_b = rd_busy[1];

endmodule

// File: tb/tb_register_file_scoreboarded.sv
// Directed bench for register_file_scoreboarded: a vector table plus hand sequences
// for the no-bypass variant and asynchronous reset in mid-operation.
module tb_register_file_scoreboarded;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  select_a = '0, select_b = '0;
  logic        write = 1'b0, reserve = 1'b0;
  logic [4:0]  address = '0, reserve_address = '0;
  logic [63:0] data_in = '0;
  logic [63:0] out_a, out_b, nb_out_a, nb_out_b;
  logic        busy_a, busy_b, nb_busy_a, nb_busy_b;
  logic [5:0]  busy_count, nb_busy_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  register_file_scoreboarded #(.BYPASS(1)) dut (
    .clock(clock), .reset(reset), .select_a(select_a), .select_b(select_b),
    .out_a(out_a), .out_b(out_b), .busy_a(busy_a), .busy_b(busy_b),
    .write(write), .address(address), .data_in(data_in),
    .reserve(reserve), .reserve_address(reserve_address), .busy_count(busy_count)
  );

  register_file_scoreboarded #(.BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset), .select_a(select_a), .select_b(select_b),
    .out_a(nb_out_a), .out_b(nb_out_b), .busy_a(nb_busy_a), .busy_b(nb_busy_b),
    .write(write), .address(address), .data_in(data_in),
    .reserve(reserve), .reserve_address(reserve_address), .busy_count(nb_busy_count)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [63:0] din;
    logic        rsv;
    logic [4:0]  raddr;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [63:0] ea;
    logic [63:0] eb;
    logic        eba;
    logic        ebb;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [4:0] addr, input logic [63:0] din,
                       input logic rsv, input logic [4:0] raddr,
                       input logic [4:0] sa, input logic [4:0] sb);
    write = wr; address = addr; data_in = din;
    reserve = rsv; reserve_address = raddr;
    select_a = sa; select_b = sb;
  endtask

  task automatic check_all(input string tag, input logic [63:0] ea, input logic [63:0] eb,
                           input logic eba, input logic ebb, input logic [5:0] ecnt);
    chk({tag, ".out_a"}, out_a, ea);
    chk({tag, ".out_b"}, out_b, eb);
    chk({tag, ".busy_a"}, 64'(busy_a), 64'(eba));
    chk({tag, ".busy_b"}, 64'(busy_b), 64'(ebb));
    chk({tag, ".busy_count"}, 64'(busy_count), 64'(ecnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    //          wr  addr  din                    rsv raddr sa  sb  ea                     eb                     eba  ebb  cnt
    vecs[0]  = '{0, 5'd0, 64'h0,                 0, 5'd0, 5'd0, 5'd30, 64'h0,                64'h0,                0, 0, 6'd0};
    vecs[1]  = '{1, 5'd5, 64'hDEAD_BEEF_0123_4567, 0, 5'd0, 5'd5, 5'd1, 64'hDEAD_BEEF_0123_4567, 64'h0,          0, 0, 6'd0};
    vecs[2]  = '{0, 5'd0, 64'h0,                 0, 5'd0, 5'd5, 5'd7, 64'hDEAD_BEEF_0123_4567, 64'h0,             0, 0, 6'd0};
    vecs[3]  = '{1, 5'd7, 64'h1234,              0, 5'd0, 5'd5, 5'd7, 64'hDEAD_BEEF_0123_4567, 64'h1234,          0, 0, 6'd0};
    vecs[4]  = '{0, 5'd0, 64'h0,                 0, 5'd0, 5'd7, 5'd5, 64'h1234,             64'hDEAD_BEEF_0123_4567, 0, 0, 6'd0};
    vecs[5]  = '{1, 5'd31, '1,                   1, 5'd31, 5'd31, 5'd31, 64'h0,             64'h0,                0, 0, 6'd0};
    vecs[6]  = '{0, 5'd0, 64'h0,                 0, 5'd0, 5'd31, 5'd5, 64'h0,               64'hDEAD_BEEF_0123_4567, 0, 0, 6'd0};
    vecs[7]  = '{0, 5'd0, 64'h0,                 1, 5'd3, 5'd3, 5'd4, 64'h0,                64'h0,                0, 0, 6'd0};
    vecs[8]  = '{0, 5'd0, 64'h0,                 1, 5'd4, 5'd3, 5'd4, 64'h0,                64'h0,                1, 0, 6'd1};
    vecs[9]  = '{0, 5'd0, 64'h0,                 0, 5'd0, 5'd3, 5'd4, 64'h0,                64'h0,                1, 1, 6'd2};
    vecs[10] = '{1, 5'd3, 64'hAAAA,              0, 5'd0, 5'd3, 5'd4, 64'hAAAA,             64'h0,                0, 1, 6'd2};
    vecs[11] = '{1, 5'd4, 64'h5555,              1, 5'd4, 5'd3, 5'd5, 64'hAAAA,             64'hDEAD_BEEF_0123_4567, 0, 0, 6'd1};
    vecs[12] = '{0, 5'd0, 64'h0,                 0, 5'd0, 5'd4, 5'd3, 64'h5555,             64'hAAAA,             1, 0, 6'd1};

    // Reset held across a clock edge with a write pending: outputs stay zero.
    drive(1, 5'd1, 64'hFFFF, 1, 5'd1, 5'd1, 5'd30);
    @(posedge clock); #1;
    check_all("reset_hold", 64'h0, 64'h0, 0, 0, 6'd0);
    drive(0, 5'd0, 64'h0, 0, 5'd0, 5'd0, 5'd0);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].rsv, vecs[i].raddr, vecs[i].sa, vecs[i].sb);
      #2;
      check_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].eba, vecs[i].ebb, vecs[i].ecnt);
      @(posedge clock); #1;
    end

    // Bypass versus stored-only reads of a same-cycle write.
    drive(1, 5'd9, 64'h77, 0, 5'd0, 5'd9, 5'd9);
    #2;
    chk("bypass.out_b", out_b, 64'h77);
    chk("nobypass.out_b_before", nb_out_b, 64'h0);
    @(posedge clock); #1;
    drive(0, 5'd0, 64'h0, 0, 5'd0, 5'd9, 5'd9);
    #1;
    chk("nobypass.out_b_after", nb_out_b, 64'h77);
    @(posedge clock); #1;

    // Fill regs 1..30, reserving 2 and 9 after they have been written.
    for (int i = 1; i <= 30; i++) begin
      drive(1, 5'(i), 64'(i) * 64'h0101_0101_0101_0101,
            (i == 5) || (i == 12), (i == 5) ? 5'd2 : 5'd9, 5'd0, 5'd0);
      @(posedge clock); #1;
    end
    drive(0, 5'd0, 64'h0, 0, 5'd0, 5'd17, 5'd2);
    #2;
    check_all("filled", 64'h1111_1111_1111_1111, 64'h0202_0202_0202_0202, 0, 1, 6'd2);

    // Asynchronous reset between edges, with a bypassable write on the inputs.
    drive(1, 5'd1, 64'hFF, 0, 5'd0, 5'd1, 5'd2);
    reset = 1'b0;
    #1;
    check_all("async_reset", 64'h0, 64'h0, 0, 0, 6'd0);
    select_b = 5'd9;
    #1;
    chk("async_reset.busy_b9", 64'(busy_b), 64'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    drive(0, 5'd0, 64'h0, 0, 5'd0, 5'd1, 5'd17);
    #1;
    chk("post_reset.out_a", out_a, 64'h0);
    chk("post_reset.out_b", out_b, 64'h0);
    chk("post_reset.busy_count", 64'(busy_count), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
